regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised integer register file for the RV32i core: 2 combinational read ports and 1 write port.
- Same-cycle write-to-read bypass, so writes can move to the rising edge.
- Per-register pending-write scoreboard, giving hazard detection for multi-cycle producers such as loads.
- Multi-cycle synchronous clear sequencer, used for context reset without asserting global rst.

Parameters:
- XLEN, 32, data width of each register.
- AW, 5, address width; number of registers NREGS = 2**AW.
- ZERO_REG, 1, when 1, register 0 is hardwired to zero and is never pending; when 0, register 0 is an ordinary register.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd_addr_A  in  AW  read address, port A.
- rd_addr_B  in  AW  read address, port B.
- rd_data_A  out  XLEN  read data, port A (combinational).
- rd_data_B  out  XLEN  read data, port B (combinational).
- rd_busy_A  out  1  register addressed on port A has an outstanding write.
- rd_busy_B  out  1  register addressed on port B has an outstanding write.
- wt_addr  in  AW  write address.
- wt_data  in  XLEN  write data.
- L_S  in  1  write enable.
- iss_valid  in  1  issue: mark iss_addr as pending.
- iss_addr  in  AW  destination register of issued instruction.
- clr_req  in  1  request sequential clear of all registers.
- clr_busy  out  1  clear sequence in progress.

Behaviour:
- Reset (async, rst=1):
  - all registers = 0, all pending bits = 0.
  - FSM = IDLE, clr_busy = 0, clear index = 1.
  - Outputs follow combinationally: rd_data = 0, rd_busy = 0.
- "Zero address" means addr==0 with ZERO_REG=1.
- Read, per port, priority order:
  - zero address -> data 0, busy 0;
  - else L_S=1, wt_addr==rd_addr, FSM=IDLE -> data = wt_data (bypass), busy 0;
  - else data = register[rd_addr], busy = pending[rd_addr].
- Write: rising edge with L_S=1, FSM=IDLE, not zero address -> register[wt_addr] <= wt_data and pending[wt_addr] <= 0.
- Issue: rising edge with iss_valid=1, FSM=IDLE, not zero address -> pending[iss_addr] <= 1.
- Write and issue to the same address on the same edge: data is written and pending ends 1 (the new producer wins).
- Write and issue to different addresses on the same edge: both take effect.
- Clear FSM, states IDLE and CLEAR:
  - IDLE, clr_req=1 at edge k -> CLEAR.
    - All pending bits <= 0 at edge k.
    - Index <= 1 if ZERO_REG=1, else 0.
    - clr_busy = 1 after edge k.
  - CLEAR: each edge writes 0 to register[index] and increments the index.
  - After the edge that writes register NREGS-1 -> IDLE, clr_busy = 0, index reset.
  - clr_busy is high for NREGS-1 cycles (ZERO_REG=1) or NREGS cycles (ZERO_REG=0).
  - During CLEAR: L_S and iss_valid are ignored, no bypass, clr_req is ignored.
  - Reads return current array contents, partially cleared; consumers must stall on clr_busy.
  - clr_req held high on the edge that returns to IDLE: not restarted. The FSM must spend at least one cycle in IDLE.
- Reset mid-clear: immediate IDLE with everything zero; no residual sequence.
- Width rules: index is AW+1 bits internally to detect wrap; no truncation of wt_data.

Decomposition:
- Shared package regfile_pkg holds:
  - the XLEN default;
  - the AW default;
  - the FSM state enum {IDLE, CLEAR};
  - an NREGS helper constant.
- One natural sub-module: regfile_sb_scoreboard.
  - Owns the pending bit vector, set/clear/priority logic and flush-all.
  - Exports a pending vector; the top does the read-port muxing.
- The clear FSM and data array stay in the top.

Test Plan:
- Reset then read: rst pulse, read A=5, B=0 -> rd_data 0/0, rd_busy 0/0, clr_busy 0.
- Write/bypass: L_S=1, wt_addr=3, wt_data=0xDEADBEEF, rd_addr_A=3 in the same cycle -> rd_data_A=0xDEADBEEF before the edge. Next cycle with L_S=0 -> still 0xDEADBEEF. A write to addr 0 -> reads 0.
- Scoreboard:
  - iss_valid, iss_addr=7 -> next cycle rd_busy_A(7)=1.
  - L_S to 7 with 0x55 -> same cycle rd_busy_A=0 with data 0x55; stays 0 afterwards.
  - Simultaneous iss and L_S to 7 -> pending stays 1.
- Clear sequence (AW=5, ZERO_REG=1):
  - fill x1..x31 with nonzero values, pulse clr_req -> clr_busy high exactly 31 cycles.
  - Afterwards every register reads 0 and no busy bits are set.
  - L_S during CLEAR has no effect.
- Reset mid-clear: assert rst 10 cycles into CLEAR -> clr_busy=0 immediately and all registers 0. A new clr_req afterwards completes normally.
- Parameter sweep: XLEN=64, AW=3, ZERO_REG=0.
  - Write reg 0 = 0x1_0000_0000 -> reads back 0x1_0000_0000.
  - clr_req -> clr_busy high for 8 cycles.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the regfile_sb register file: default widths and
// the clear-sequencer state encoding.
package regfile_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int AW_DEF    = 5;
   localparam int NREGS_DEF = 2 ** AW_DEF;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_e;

   function automatic int nregs(input int aw);
      return 2 ** aw;
   endfunction

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on
// write-back, flushed all at once when a context clear starts.
module regfile_sb_scoreboard
   import regfile_pkg::*;
#(
   parameter int AW = AW_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              set_en,
   input  logic [AW-1:0]     set_addr,
   input  logic              clr_en,
   input  logic [AW-1:0]     clr_addr,
   input  logic              flush,
   output logic [2**AW-1:0]  pending
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending <= '0;
      end else if (flush) begin
         pending <= '0;
      end else begin
         if (clr_en) pending[clr_addr] <= 1'b0;
         // NOTE: the later non-blocking assignment wins, so a new producer
         // issued on the same edge as a write-back leaves the bit set.
         if (set_en) pending[set_addr] <= 1'b1;
      end
   end

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with two combinational read ports, write bypass,
// pending-write scoreboard and a multi-cycle synchronous clear sequencer.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int XLEN     = XLEN_DEF,
   parameter int AW       = AW_DEF,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   rd_addr_A,
   input  logic [AW-1:0]   rd_addr_B,
   output logic [XLEN-1:0] rd_data_A,
   output logic [XLEN-1:0] rd_data_B,
   output logic            rd_busy_A,
   output logic            rd_busy_B,
   input  logic [AW-1:0]   wt_addr,
   input  logic [XLEN-1:0] wt_data,
   input  logic            L_S,
   input  logic            iss_valid,
   input  logic [AW-1:0]   iss_addr,
   input  logic            clr_req,
   output logic            clr_busy
);

   localparam int NREGS = nregs(AW);
   localparam logic [AW:0] IDX_ONE   = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0] IDX_START = ZERO_REG ? IDX_ONE : '0;

   logic [XLEN-1:0] regs [NREGS];
   logic [NREGS-1:0] pending;
   clr_state_e       state;
   logic [AW:0]      idx;
   logic [AW:0]      idx_nxt;
   logic             idle;
   logic             wr_fire;
   logic             iss_fire;

   function automatic logic is_zero(input logic [AW-1:0] a);
      return ZERO_REG && (a == '0);
   endfunction

   assign idle     = (state == IDLE);
   assign wr_fire  = idle && L_S && !is_zero(wt_addr);
   assign iss_fire = idle && iss_valid && !is_zero(iss_addr);
   // Extra index bit carries out after the last register.
   assign idx_nxt  = idx + IDX_ONE;

   regfile_sb_scoreboard #(.AW(AW)) u_sb (
      .clk      (clk),
      .rst      (rst),
      .set_en   (iss_fire),
      .set_addr (iss_addr),
      .clr_en   (wr_fire),
      .clr_addr (wt_addr),
      .flush    (idle && clr_req),
      .pending  (pending)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         idx      <= IDX_ONE;
         clr_busy <= 1'b0;
         // NOTE: the array is reset because a context must start from all
         // zeros; this is what forbids mapping it onto a RAM macro.
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (wr_fire) regs[wt_addr] <= wt_data;
               if (clr_req) begin
                  state    <= CLEAR;
                  idx      <= IDX_START;
                  clr_busy <= 1'b1;
               end
            end
            CLEAR: begin
               regs[idx[AW-1:0]] <= '0;
               if (idx_nxt[AW]) begin
                  state    <= IDLE;
                  idx      <= IDX_ONE;
                  clr_busy <= 1'b0;
               end else begin
                  idx <= idx_nxt;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      rd_data_A = regs[rd_addr_A];
      rd_busy_A = pending[rd_addr_A];
      if (is_zero(rd_addr_A)) begin
         rd_data_A = '0;
         rd_busy_A = 1'b0;
      end else if (idle && L_S && (wt_addr == rd_addr_A)) begin
         rd_data_A = wt_data;
         rd_busy_A = 1'b0;
      end
   end

   always_comb begin
      rd_data_B = regs[rd_addr_B];
      rd_busy_B = pending[rd_addr_B];
      if (is_zero(rd_addr_B)) begin
         rd_data_B = '0;
         rd_busy_B = 1'b0;
      end else if (idle && L_S && (wt_addr == rd_addr_B)) begin
         rd_data_B = wt_data;
         rd_busy_B = 1'b0;
      end
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed vectors, clear/reset corner
// sequences, randomized traffic against a reference model, and a 64-bit variant.
module tb_regfile_sb;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // default instance: XLEN=32, AW=5, ZERO_REG=1
   logic [4:0]  ra, rb, wa, ia;
   logic [31:0] wd, rda, rdb;
   logic        ls, iss, clr, bsa, bsb, cb;

   regfile_sb dut (
      .clk(clk), .rst(rst),
      .rd_addr_A(ra), .rd_addr_B(rb), .rd_data_A(rda), .rd_data_B(rdb),
      .rd_busy_A(bsa), .rd_busy_B(bsb),
      .wt_addr(wa), .wt_data(wd), .L_S(ls),
      .iss_valid(iss), .iss_addr(ia), .clr_req(clr), .clr_busy(cb)
   );

   // variant instance: XLEN=64, AW=3, ZERO_REG=0
   logic [2:0]  p_ra, p_rb, p_wa, p_ia;
   logic [63:0] p_wd, p_rda, p_rdb;
   logic        p_ls, p_iss, p_clr, p_bsa, p_bsb, p_cb;

   regfile_sb #(.XLEN(64), .AW(3), .ZERO_REG(1'b0)) dut64 (
      .clk(clk), .rst(rst),
      .rd_addr_A(p_ra), .rd_addr_B(p_rb), .rd_data_A(p_rda), .rd_data_B(p_rdb),
      .rd_busy_A(p_bsa), .rd_busy_B(p_bsb),
      .wt_addr(p_wa), .wt_data(p_wd), .L_S(p_ls),
      .iss_valid(p_iss), .iss_addr(p_ia), .clr_req(p_clr), .clr_busy(p_cb)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference model: architectural contents, pending flags, and the clear
   // sequence as "cycles left" plus the next register to be zeroed.
   logic [31:0] m_mem [32];
   bit          m_pend [32];
   int          m_left;
   int          m_next;

   function automatic logic [31:0] exp_data(input logic [4:0] a);
      if (a == 0) return 32'h0;
      if (m_left == 0 && ls && wa == a) return wd;
      return m_mem[a];
   endfunction

   function automatic bit exp_busy(input logic [4:0] a);
      if (a == 0) return 1'b0;
      if (m_left == 0 && ls && wa == a) return 1'b0;
      return m_pend[a];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         m_mem[i]  = '0;
         m_pend[i] = 1'b0;
      end
      m_left = 0;
      m_next = 1;
   endtask

   task automatic model_edge();
      if (m_left == 0) begin
         if (ls && wa != 0) begin
            m_mem[wa]  = wd;
            m_pend[wa] = 1'b0;
         end
         if (iss && ia != 0) m_pend[ia] = 1'b1;
         if (clr) begin
            for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
            m_left = 31;
            m_next = 1;
         end
      end else begin
         m_mem[m_next] = '0;
         m_next++;
         m_left--;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      ls = 0; iss = 0; clr = 0; wa = 0; ia = 0; wd = 0;
   endtask

   task automatic check_ports();
      check("rd_data_A", rda, exp_data(ra));
      check("rd_data_B", rdb, exp_data(rb));
      check("rd_busy_A", bsa, exp_busy(ra));
      check("rd_busy_B", bsb, exp_busy(rb));
      check("clr_busy",  cb,  m_left != 0);
   endtask

   task automatic fill_regs();
      for (int i = 1; i < 32; i++) begin
         ls = 1; wa = 5'(i); wd = 32'h0101_0101 * i + 32'h1;
         tick();
      end
      idle_inputs();
   endtask

   // Pulses clr_req, keeps L_S/iss active throughout, and returns the number
   // of cycles clr_busy stayed high.
   task automatic run_clear(output int cnt);
      cnt = 0;
      clr = 1; #1; tick(); clr = 0;
      while (cb && cnt < 100) begin
         ls = 1; wa = 5'($urandom_range(1, 31)); wd = $urandom;
         iss = 1; ia = 5'($urandom_range(1, 31));
         clr = 1'($urandom_range(0, 1));
         ra = 5'($urandom); rb = wa;
         #1; check_ports();
         cnt++;
         tick();
      end
      idle_inputs();
   endtask

   task automatic check_all_zero(input string tag);
      for (int i = 0; i < 32; i++) begin
         ra = 5'(i); rb = 5'(31 - i); #1;
         check({tag, "_data"}, rda, 32'h0);
         check({tag, "_busy"}, bsa, 1'b0);
      end
   endtask

   typedef struct {
      bit          ls;
      logic [4:0]  wa;
      logic [31:0] wd;
      bit          iss;
      logic [4:0]  ia;
      logic [4:0]  ra;
      logic [4:0]  rb;
      logic [31:0] ea;
      logic [31:0] eb;
      bit          ba;
      bit          bb;
   } vec_t;

   vec_t vt [15];
   int   cnt;

   initial begin
      vt[0]  = '{0, 5'd0, 32'h0,        0, 5'd0, 5'd5, 5'd0, 32'h0,        32'h0,        0, 0};
      vt[1]  = '{1, 5'd3, 32'hDEADBEEF, 0, 5'd0, 5'd3, 5'd0, 32'hDEADBEEF, 32'h0,        0, 0};
      vt[2]  = '{0, 5'd0, 32'h0,        0, 5'd0, 5'd3, 5'd0, 32'hDEADBEEF, 32'h0,        0, 0};
      vt[3]  = '{1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 5'd0, 5'd3, 32'h0,        32'hDEADBEEF, 0, 0};
      vt[4]  = '{0, 5'd0, 32'h0,        0, 5'd0, 5'd0, 5'd3, 32'h0,        32'hDEADBEEF, 0, 0};
      vt[5]  = '{0, 5'd0, 32'h0,        1, 5'd7, 5'd7, 5'd3, 32'h0,        32'hDEADBEEF, 0, 0};
      vt[6]  = '{0, 5'd0, 32'h0,        0, 5'd0, 5'd7, 5'd3, 32'h0,        32'hDEADBEEF, 1, 0};
      vt[7]  = '{1, 5'd7, 32'h55,       0, 5'd0, 5'd7, 5'd7, 32'h55,       32'h55,       0, 0};
      vt[8]  = '{0, 5'd0, 32'h0,        0, 5'd0, 5'd7, 5'd3, 32'h55,       32'hDEADBEEF, 0, 0};
      vt[9]  = '{1, 5'd7, 32'h66,       1, 5'd7, 5'd7, 5'd7, 32'h66,       32'h66,       0, 0};
      vt[10] = '{0, 5'd0, 32'h0,        0, 5'd0, 5'd7, 5'd7, 32'h66,       32'h66,       1, 1};
      vt[11] = '{0, 5'd0, 32'h0,        1, 5'd0, 5'd0, 5'd7, 32'h0,        32'h66,       0, 1};
      vt[12] = '{0, 5'd0, 32'h0,        0, 5'd0, 5'd0, 5'd7, 32'h0,        32'h66,       0, 1};
      vt[13] = '{1, 5'd3, 32'h12345678, 1, 5'd9, 5'd9, 5'd3, 32'h0,        32'h12345678, 0, 0};
      vt[14] = '{0, 5'd0, 32'h0,        0, 5'd0, 5'd9, 5'd3, 32'h0,        32'h12345678, 1, 0};

      idle_inputs(); ra = 5; rb = 0;
      p_ls = 0; p_iss = 0; p_clr = 0; p_wa = 0; p_ia = 0; p_wd = 0; p_ra = 0; p_rb = 1;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      check("reset_clr_busy", cb, 1'b0);
      check("reset_data_A", rda, 32'h0);
      rst = 0;

      // directed vectors
      for (int i = 0; i < 15; i++) begin
         ls = vt[i].ls; wa = vt[i].wa; wd = vt[i].wd;
         iss = vt[i].iss; ia = vt[i].ia; ra = vt[i].ra; rb = vt[i].rb;
         #1;
         check($sformatf("vec%0d_data_A", i), rda, vt[i].ea);
         check($sformatf("vec%0d_data_B", i), rdb, vt[i].eb);
         check($sformatf("vec%0d_busy_A", i), bsa, vt[i].ba);
         check($sformatf("vec%0d_busy_B", i), bsb, vt[i].bb);
         check($sformatf("vec%0d_clr_busy", i), cb, 1'b0);
         tick();
      end
      idle_inputs();

      // full clear with L_S / iss / clr_req hammered during CLEAR
      fill_regs();
      ia = 5'd12; iss = 1; tick(); iss = 0;
      run_clear(cnt);
      check("clear_cycles", cnt, 31);
      check_all_zero("after_clear");

      // reset partway into a clear, then a clean clear afterwards
      fill_regs();
      clr = 1; tick(); clr = 0;
      repeat (10) tick();
      ra = 5'd20; #1;
      check("mid_clear_busy", cb, 1'b1);
      check("mid_clear_partial", rda, exp_data(5'd20));
      rst = 1; #1;
      check("rst_mid_clear_busy", cb, 1'b0);
      check_all_zero("rst_mid_clear");
      @(negedge clk);
      rst = 0;
      model_reset();
      fill_regs();
      run_clear(cnt);
      check("clear_after_rst_cycles", cnt, 31);
      check_all_zero("after_rst_clear");

      // randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         ls  = 1'($urandom_range(0, 1));
         wa  = 5'($urandom);
         wd  = $urandom;
         iss = 1'($urandom_range(0, 1));
         ia  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
         clr = ($urandom_range(0, 59) == 0);
         ra  = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom);
         rb  = ($urandom_range(0, 2) == 0) ? ia : 5'($urandom);
         #1;
         check_ports();
         tick();
      end
      idle_inputs();

      // 64-bit, 8-register, ordinary-register-0 variant
      p_ls = 1; p_wa = 0; p_wd = 64'h1_0000_0000; p_ra = 0; #1;
      check("w64_bypass", p_rda, 64'h1_0000_0000);
      @(negedge clk);
      p_ls = 0; p_iss = 1; p_ia = 0; #1;
      check("w64_readback", p_rda, 64'h1_0000_0000);
      @(negedge clk);
      p_iss = 0; #1;
      check("w64_reg0_pending", p_bsa, 1'b1);
      p_clr = 1; @(negedge clk); p_clr = 0;
      cnt = 0;
      while (p_cb && cnt < 100) begin
         cnt++;
         @(negedge clk);
      end
      check("w64_clear_cycles", cnt, 8);
      #1;
      check("w64_reg0_cleared", p_rda, 64'h0);
      check("w64_reg0_not_pending", p_bsa, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
